traffic_phase_ctrl: RTL

Parametrised multi-direction intersection controller. It sequences NUM_DIR approach directions round-robin through left-turn, green, yellow and all-red clearance phases, using per-phase durations set by parameters. It supports optional demand-based skipping and emergency preemption with a safe yellow/all-red exit and resumption of the interrupted phase. It sits at the top of the traffic subsystem and drives the lamp outputs of every approach directly.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_dir_select.sv | 29 ++
 rtl/traffic_phase_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: phase enum, lamp encodings and the saved preemption context
// shared by the intersection controller files.
package traffic_pkg;

    typedef enum logic [2:0] {PH_LEFT, PH_GREEN, PH_YELLOW, PH_ALLRED, PH_HOLD} phase_e;

    localparam logic [3:0] LAMP_LEFT   = 4'b1001;
    localparam logic [3:0] LAMP_GREEN  = 4'b0100;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_RED    = 4'b0001;

    // Sized for the largest supported intersection (8 dirs) and counter (16 bits)
    typedef struct packed {
        logic [2:0]  dir;
        phase_e      phase;
        logic [15:0] count;
        logic        done;
    } ctx_t;

    function automatic ctx_t mk_ctx(logic [2:0] dir, phase_e phase, logic [15:0] count, logic done);
        ctx_t c;
        c.dir   = dir;
        c.phase = phase;
        c.count = count;
        c.done  = done;
        return c;
    endfunction

endpackage

// File: rtl/traffic_dir_select.sv
// traffic_dir_select: picks the next direction to serve, either plain
// round-robin or the first demanding direction after cur_dir in wrap order.
module traffic_dir_select
    import traffic_pkg::*;
#(
    parameter int NUM_DIR = 2,
    parameter int SKIP_EN = 0
) (
    input  logic [$clog2(NUM_DIR)-1:0] cur_dir,
    input  logic [NUM_DIR-1:0]         req,
    output logic [$clog2(NUM_DIR)-1:0] next_dir
);
    localparam int DW = $clog2(NUM_DIR);

    logic [DW-1:0] rr, pick, idx;

    // Scan farthest-first so the nearest requesting direction wins; cur_dir is last
    always_comb begin
        rr   = DW'((int'(cur_dir) + 1) % NUM_DIR);
        pick = rr;
        idx  = '0;
        for (int k = NUM_DIR; k >= 1; k--) begin
            idx = DW'((int'(cur_dir) + k) % NUM_DIR);
            if (req[idx]) pick = idx;
        end
        next_dir = (SKIP_EN != 0 && |req) ? pick : rr;
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin intersection sequencer with optional demand
// skipping and emergency preemption that resumes the interrupted phase.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_DIR    = 2,
    parameter int LEFT_CYC   = 5,
    parameter int GREEN_CYC  = 10,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 1,
    parameter int SKIP_EN    = 0,
    parameter int CNT_W      = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       emergency,
    input  logic [NUM_DIR-1:0]         req,
    output logic [4*NUM_DIR-1:0]       lights,
    output logic [$clog2(NUM_DIR)-1:0] cur_dir,
    output logic                       preempt_active
);
    localparam int DW = $clog2(NUM_DIR);

    phase_e         phase_q, phase_d;
    logic [DW-1:0]  dir_q, dir_d, next_dir;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctx_t           ctx_q, ctx_d;
    logic           saved_q, saved_d, forced_q, forced_d;
    logic           last, take, resume;

    function automatic logic [CNT_W-1:0] plen(phase_e p);
        return p == PH_LEFT   ? CNT_W'(LEFT_CYC)   :
               p == PH_GREEN  ? CNT_W'(GREEN_CYC)  :
               p == PH_YELLOW ? CNT_W'(YELLOW_CYC) : CNT_W'(ALLRED_CYC);
    endfunction

    traffic_dir_select #(.NUM_DIR(NUM_DIR), .SKIP_EN(SKIP_EN)) u_sel (
        .cur_dir  (dir_q),
        .req      (req),
        .next_dir (next_dir)
    );

    assign last   = cnt_q == plen(phase_q) - 1'b1;
    assign take   = emergency && !forced_q;
    assign resume = saved_q && !ctx_q.done && CNT_W'(ctx_q.count) != plen(ctx_q.phase);

    always_comb begin
        phase_d  = phase_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q + 1'b1;
        ctx_d    = ctx_q;
        saved_d  = saved_q;
        forced_d = forced_q;
        if (phase_q == PH_HOLD) begin
            cnt_d   = '0;
            phase_d = emergency ? PH_HOLD : PH_ALLRED;
        end else if (take && (phase_q == PH_LEFT || phase_q == PH_GREEN)) begin
            ctx_d    = mk_ctx(3'(dir_q), phase_q, 16'(cnt_q + 1'b1), 1'b0);
            saved_d  = 1'b1;
            forced_d = 1'b1;
            phase_d  = PH_YELLOW;
            cnt_d    = '0;
        end else if (take && phase_q == PH_ALLRED) begin
            // A clearance that follows HOLD keeps the context it already holds
            if (!saved_q) ctx_d = mk_ctx(3'(dir_q), phase_q, '0, 1'b1);
            saved_d = 1'b1;
            phase_d = PH_HOLD;
            cnt_d   = '0;
        end else if (phase_q == PH_YELLOW && (take || forced_q)) begin
            if (take) ctx_d = mk_ctx(3'(dir_q), phase_q, '0, 1'b1);
            saved_d  = 1'b1;
            forced_d = !last;
            phase_d  = last ? PH_HOLD : PH_YELLOW;
            cnt_d    = last ? '0 : cnt_q + 1'b1;
        end else if (last) begin
            cnt_d = '0;
            case (phase_q)
                PH_LEFT:   phase_d = PH_GREEN;
                PH_GREEN:  phase_d = PH_YELLOW;
                PH_YELLOW: phase_d = PH_ALLRED;
                PH_ALLRED: begin
                    phase_d = resume ? ctx_q.phase : PH_LEFT;
                    dir_d   = resume ? DW'(ctx_q.dir) : next_dir;
                    cnt_d   = resume ? CNT_W'(ctx_q.count) : '0;
                    saved_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_LEFT;
            dir_q    <= '0;
            cnt_q    <= '0;
            ctx_q    <= '0;
            saved_q  <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            ctx_q    <= ctx_d;
            saved_q  <= saved_d;
            forced_q <= forced_d;
        end
    end

    for (genvar d = 0; d < NUM_DIR; d++) begin : g_lamp
        assign lights[4*d +: 4] = (DW'(d) != dir_q)    ? LAMP_RED    :
                                  (phase_q == PH_LEFT)   ? LAMP_LEFT   :
                                  (phase_q == PH_GREEN)  ? LAMP_GREEN  :
                                  (phase_q == PH_YELLOW) ? LAMP_YELLOW : LAMP_RED;
    end

    assign cur_dir        = dir_q;
    assign preempt_active = phase_q == PH_HOLD || forced_q;

endmodule
